// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/next-PC controller with return-address stack
module pc_sequencer #(
    parameter int              ADDR_W      = 16,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              re,
    input  logic              start,
    input  logic              halt,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              ir_load,
    input  logic              jump_req,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic [ADDR_W-1:0] target,
    output logic              pc_re,
    output logic              pc_incre,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_load,
    output logic              pc_cs,
    output logic              pc_w,
    output logic              pc_r,
    output logic              busy,
    output logic              fault
);

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam int IX_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FETCH, S_DECODE, S_UPDATE, S_HALT, S_FAULT
    } state_t;

    state_t            state, state_d;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_m1;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic              upd_seq;
    logic [ADDR_W-1:0] upd_val;
    logic              halt_seen;
    logic              fault_q;
    logic              stack_empty, stack_full, dec_fault;

    assign sp_m1       = sp - SP_W'(1);
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    // ret outranks call, so a call only faults when no ret is pending
    assign dec_fault   = ret_req ? stack_empty : (call_req && stack_full);

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (start) state_d = S_START;
            S_START:  state_d = S_FETCH;
            S_FETCH:  if (mem_ack) state_d = S_DECODE;
            S_DECODE: state_d = dec_fault ? S_FAULT : S_UPDATE;
            S_UPDATE: state_d = (halt_seen || halt) ? S_HALT : S_FETCH;
            S_HALT:   if (start) state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        ir_load  = 1'b0;
        pc_re    = 1'b0;
        pc_incre = 1'b0;
        pc_sel   = 1'b0;
        pc_load  = '0;
        pc_cs    = 1'b0;
        pc_w     = 1'b0;
        pc_r     = 1'b1;
        busy     = !(state == S_IDLE || state == S_HALT || state == S_FAULT);
        fault    = fault_q;
        case (state)
            S_START: begin
                pc_re   = 1'b1;
                pc_cs   = 1'b1;
                pc_w    = 1'b1;
                pc_sel  = 1'b1;
                pc_load = RESET_VEC;
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_value;
                ir_load  = mem_ack;
            end
            S_UPDATE: begin
                pc_cs    = 1'b1;
                pc_w     = 1'b1;
                pc_incre = upd_seq;
                pc_sel   = !upd_seq;
                pc_load  = upd_seq ? '0 : upd_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge re) begin
        if (re) begin
            state     <= S_IDLE;
            sp        <= '0;
            upd_seq   <= 1'b1;
            upd_val   <= '0;
            halt_seen <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state <= state_d;
            // halt requests accumulate until the UPDATE that honours them
            case (state)
                S_IDLE, S_HALT: halt_seen <= start && halt;
                S_UPDATE:       halt_seen <= 1'b0;
                default:        halt_seen <= halt_seen || halt;
            endcase
            if (state == S_DECODE) begin
                if (dec_fault) begin
                    fault_q <= 1'b1;
                end else if (ret_req) begin
                    upd_seq <= 1'b0;
                    upd_val <= stack_mem[sp_m1[IX_W-1:0]];
                    sp      <= sp_m1;
                end else if (call_req) begin
                    upd_seq <= 1'b0;
                    upd_val <= target;
                    sp      <= sp + SP_W'(1);
                end else if (jump_req) begin
                    upd_seq <= 1'b0;
                    upd_val <= target;
                end else begin
                    upd_seq <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DECODE && !ret_req && call_req && !stack_full)
            stack_mem[sp[IX_W-1:0]] <= pc_value + ADDR_W'(1);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        re = 1'b0, start = 1'b0, halt = 1'b0;
    logic [15:0] pc_value;
    logic        mem_req, mem_ack = 1'b0, ir_load;
    logic [15:0] mem_addr;
    logic        jump_req = 1'b0, call_req = 1'b0, ret_req = 1'b0;
    logic [15:0] target = '0;
    logic        pc_re, pc_incre, pc_sel, pc_cs, pc_w, pc_r, busy, fault;
    logic [15:0] pc_load;

    logic [15:0] pc_reg = 16'h1234;
    logic [15:0] cur_pc;
    logic [15:0] mstack [$];
    int          n_total = 0, n_pass = 0;

    typedef struct {
        logic        j, c, r;
        logic [15:0] tgt;
        int          dly;
        logic [15:0] exp_pc;
        logic        exp_flt;
    } vec_t;
    vec_t tbl [13];

    pc_sequencer #(.ADDR_W(16), .STACK_DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .re(re), .start(start), .halt(halt), .pc_value(pc_value),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .ir_load(ir_load),
        .jump_req(jump_req), .call_req(call_req), .ret_req(ret_req), .target(target),
        .pc_re(pc_re), .pc_incre(pc_incre), .pc_sel(pc_sel), .pc_load(pc_load),
        .pc_cs(pc_cs), .pc_w(pc_w), .pc_r(pc_r), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    // PC register the sequencer controls; load takes priority over clear
    assign pc_value = pc_reg;
    always @(posedge clk) begin
        if (pc_cs && pc_w) begin
            if (pc_sel)        pc_reg <= pc_load;
            else if (pc_re)    pc_reg <= 16'h0000;
            else if (pc_incre) pc_reg <= pc_reg + 16'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        re = 1'b1;
        #1 chk("reset_outputs",
               {mem_req, ir_load, pc_re, pc_incre, pc_sel, pc_cs, pc_w, pc_r, busy, fault},
               10'b0000000100);
        chk("reset_pc_load", pc_load, 16'h0000);
        @(negedge clk);
        re = 1'b0;
        mstack.delete();
    endtask

    task automatic do_start(input logic with_halt);
        start = 1'b1;
        halt  = with_halt;
        @(negedge clk);
        start = 1'b0;
        halt  = 1'b0;
        chk("start_ctrl", {pc_re, pc_cs, pc_w, pc_sel, pc_incre, busy}, 6'b111101);
        chk("start_load", pc_load, 16'h0000);
        @(negedge clk);
        cur_pc = 16'h0000;
        chk("start_fetch_addr", {mem_req, mem_addr}, {1'b1, 16'h0000});
    endtask

    // Entered and left at a negedge; entry is the first FETCH cycle
    task automatic instr(input logic j, input logic c, input logic r, input logic [15:0] tgt,
                         input int dly, input int halt_cyc, input logic [15:0] exp_pc,
                         input logic exp_flt, input logic exp_halt);
        chk("fetch_addr", {mem_req, mem_addr}, {1'b1, cur_pc});
        for (int k = 0; k <= dly; k++) begin
            halt    = (k == halt_cyc);
            mem_ack = (k == dly);
            #1 chk("ir_load_align", {mem_req, ir_load}, {1'b1, k == dly});
            @(negedge clk);
        end
        mem_ack = 1'b0;
        halt    = 1'b0;
        chk("decode_state", {busy, mem_req, pc_w}, 3'b100);
        jump_req = j;
        call_req = c;
        ret_req  = r;
        target   = tgt;
        @(negedge clk);
        jump_req = 1'b0;
        call_req = 1'b0;
        ret_req  = 1'b0;
        if (exp_flt) begin
            chk("fault_state", {fault, busy, pc_w, pc_cs, mem_req}, 5'b10000);
            chk("fault_pc_kept", pc_reg, cur_pc);
            return;
        end
        if (!(j || c || r)) begin
            chk("update_seq", {pc_cs, pc_w, pc_sel, pc_incre}, 4'b1101);
        end else begin
            chk("update_load", {pc_cs, pc_w, pc_sel, pc_incre}, 4'b1110);
            chk("update_value", pc_load, exp_pc);
        end
        @(negedge clk);
        chk("next_pc", pc_reg, exp_pc);
        chk("after_update", {mem_req, busy, fault}, exp_halt ? 3'b000 : 3'b110);
        cur_pc = exp_pc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{0, 0, 0, 16'h0000, 0, 16'h0001, 0};
        tbl[1]  = '{0, 0, 0, 16'h0000, 0, 16'h0002, 0};
        tbl[2]  = '{0, 0, 0, 16'h0000, 1, 16'h0003, 0};
        tbl[3]  = '{1, 0, 0, 16'h0005, 0, 16'h0005, 0};
        tbl[4]  = '{1, 0, 0, 16'h0080, 2, 16'h0080, 0};
        tbl[5]  = '{1, 0, 0, 16'h000A, 0, 16'h000A, 0};
        tbl[6]  = '{0, 1, 0, 16'h0040, 0, 16'h0040, 0};
        tbl[7]  = '{0, 0, 1, 16'h0000, 0, 16'h000B, 0};
        tbl[8]  = '{0, 1, 0, 16'h0200, 0, 16'h0200, 0};
        tbl[9]  = '{0, 1, 0, 16'h0300, 3, 16'h0300, 0};
        tbl[10] = '{1, 1, 1, 16'h0999, 0, 16'h0201, 0};
        tbl[11] = '{1, 0, 0, 16'hFFFF, 0, 16'hFFFF, 0};
        tbl[12] = '{0, 0, 0, 16'h0000, 0, 16'h0000, 0};

        do_reset();
        do_start(1'b0);
        for (int i = 0; i < 13; i++)
            instr(tbl[i].j, tbl[i].c, tbl[i].r, tbl[i].tgt, tbl[i].dly, -1,
                  tbl[i].exp_pc, tbl[i].exp_flt, 1'b0);

        // stack overflow on fifth nested call
        do_reset();
        do_start(1'b0);
        for (int i = 1; i <= 5; i++)
            instr(0, 1, 0, 16'(i * 16'h100), 0, -1, 16'(i * 16'h100), i == 5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fault_sticky", {fault, busy, pc_w, mem_req}, 4'b1000);
        end
        chk("fault_pc_frozen", pc_reg, 16'h0400);

        // underflow right after reset
        do_reset();
        do_start(1'b0);
        instr(0, 0, 1, 16'h0000, 0, -1, 16'h0000, 1'b1, 1'b0);

        // halt during a slow fetch, then resume at the same PC
        do_reset();
        do_start(1'b0);
        instr(0, 0, 0, 16'h0000, 4, 2, 16'h0001, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("halt_frozen", {pc_reg, busy, pc_w, mem_req}, {16'h0001, 3'b000});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        instr(0, 0, 0, 16'h0000, 0, -1, 16'h0002, 1'b0, 1'b0);

        // start and halt together in IDLE
        do_reset();
        do_start(1'b1);
        instr(0, 0, 0, 16'h0000, 1, -1, 16'h0001, 1'b0, 1'b1);

        // reset mid-fetch and a late ack while idle
        do_reset();
        do_start(1'b0);
        re = 1'b1;
        #1 chk("async_drop", {mem_req, busy}, 2'b00);
        @(negedge clk);
        re = 1'b0;
        mem_ack = 1'b1;
        #1 chk("late_ack_ignored", {mem_req, ir_load}, 2'b00);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("still_idle", {busy, mem_req, pc_w}, 3'b000);

        // randomized programs against a queue-based stack model
        do_reset();
        do_start(1'b0);
        for (int n = 0; n < 80; n++) begin
            logic        j, c, r, f;
            logic [15:0] tgt, np;
            j   = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 4) == 0);
            tgt = 16'($urandom);
            f   = 1'b0;
            np  = cur_pc + 16'd1;
            if (r) begin
                if (mstack.size() == 0) f = 1'b1;
                else np = mstack.pop_back();
            end else if (c) begin
                if (mstack.size() == DEPTH) f = 1'b1;
                else begin
                    mstack.push_back(cur_pc + 16'd1);
                    np = tgt;
                end
            end else if (j) begin
                np = tgt;
            end
            instr(j, c, r, tgt, $urandom_range(0, 3), -1, np, f, 1'b0);
            if (f) begin
                do_reset();
                do_start(1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
